instr_mem_loader: RTL and testbench

- Instruction store that sits directly upstream of the control path.
- Holds a 64 x 16 program image. The image is loaded after reset from a byte stream; a host link or UART receiver feeds the bytes.
- Provides the instruction word at the current PC to the control path.
- Holds the CPU in reset until a complete, checksum-verified image has been written.

---
 rtl/instr_mem_loader.sv | 110 +++++++++++
 tb/tb_instr_mem_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction store loaded from a byte stream after reset; it holds the CPU in reset
// until a complete, checksum-verified image is in place, then serves words at PC.
module instr_mem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 16
) (
  input  logic              clk_main,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] PC,
  output logic [WORD_W-1:0] InstructIn,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [7:0]      MAX_N  = 8'(DEPTH);
  localparam logic [ADDR_W:0] WC_ONE = (ADDR_W+1)'(1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_RUN  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]        r_state;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W:0]   r_word_count;
  logic [7:0]        r_hi;
  logic [7:0]        r_chk;
  logic              r_cpu_reset;
  logic              r_load_done;
  logic              r_load_err;
  logic [WORD_W-1:0] r_mem [DEPTH];

  logic [ADDR_W:0]   w_wc_next;
  logic [WORD_W-1:0] w_wdata;
  logic              w_mem_we;
  logic              w_pc_in_image;

  assign w_wc_next     = r_word_count + WC_ONE;
  assign w_wdata       = {r_hi, rx_byte};
  assign w_mem_we      = rx_valid && !reset && (r_state == S_LO);
  assign w_pc_in_image = ({1'b0, PC} < r_n);

  always_ff @(posedge clk_main) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_state      <= S_IDLE;
      r_n          <= '0;
      r_word_count <= '0;
      r_hi         <= '0;
      r_chk        <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else if (rx_valid) begin
      case (r_state)
        S_IDLE: begin
          if ((rx_byte == 8'h00) || (rx_byte > MAX_N)) begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end else begin
            r_n     <= rx_byte[ADDR_W:0];
            r_chk   <= '0;
            r_state <= S_HI;
          end
        end
        S_HI: begin
          r_hi    <= rx_byte;
          r_chk   <= r_chk ^ rx_byte;
          r_state <= S_LO;
        end
        S_LO: begin
          r_chk        <= r_chk ^ rx_byte;
          r_word_count <= w_wc_next;
          r_state      <= (w_wc_next == r_n) ? S_CHK : S_HI;
        end
        S_CHK: begin
          if (rx_byte == r_chk) begin
            r_state     <= S_RUN;
            r_load_done <= 1'b1;
            r_cpu_reset <= 1'b0;
          end else begin
            r_state    <= S_ERR;
            r_load_err <= 1'b1;
          end
        end
        default: ; // RUN and ERR are terminal; stray bytes are ignored
      endcase
    end
  end

  // NOTE: the memory array has no reset; only the control state needs a known value.
  always_ff @(posedge clk_main) begin
    if (w_mem_we) r_mem[r_word_count[ADDR_W-1:0]] <= w_wdata;
  end

  // Stale words beyond the image and everything before RUN read back as zero.
  assign InstructIn = ((r_state == S_RUN) && w_pc_in_image) ? r_mem[PC] : '0;
  assign cpu_reset  = r_cpu_reset;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed loads plus random images, compared
// against a stream-parsing model that re-interprets every byte sent since the last reset.
module tb_instr_mem_loader;

  localparam int ADDR_W = 6;
  localparam int WORD_W = 16;

  logic              clk_main = 1'b0;
  logic              reset;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] PC;
  logic [WORD_W-1:0] InstructIn;
  logic              cpu_reset;
  logic              load_done;
  logic              load_err;
  logic [ADDR_W:0]   word_count;

  instr_mem_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk_main   (clk_main),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .PC         (PC),
    .InstructIn (InstructIn),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  always #5 clk_main = ~clk_main;

  int n_vec  = 0;
  int n_miss = 0;

  // Bytes accepted since the last reset, plus the model's view of them.
  logic [7:0]  q[$];
  logic [15:0] exp_img [64];
  logic [15:0] load_w  [64];
  int          exp_st;  // 0 loading, 1 running, 2 error
  int          exp_wc;
  int          exp_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Parse the stream as header, 2N data bytes, checksum; anything after is ignored.
  task automatic model();
    int avail, db;
    logic [7:0] x;
    exp_st = 0; exp_wc = 0; exp_n = 0;
    if (q.size() == 0) return;
    exp_n = int'(q[0]);
    if (exp_n == 0 || exp_n > 64) begin
      exp_st = 2; exp_n = 0;
      return;
    end
    avail = q.size() - 1;
    db    = (avail < 2 * exp_n) ? avail : 2 * exp_n;
    exp_wc = db / 2;
    for (int i = 0; i < exp_wc; i++) exp_img[i] = {q[1 + 2*i], q[2 + 2*i]};
    if (avail > 2 * exp_n) begin
      x = 8'h00;
      for (int i = 1; i <= 2 * exp_n; i++) x ^= q[i];
      exp_st = (q[2 * exp_n + 1] == x) ? 1 : 2;
    end
  endtask

  function automatic logic [15:0] exp_word(input int pc);
    return (exp_st == 1 && pc < exp_n) ? exp_img[pc] : 16'h0000;
  endfunction

  task automatic tick();
    @(posedge clk_main);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_byte = $urandom;
    tick();
    reset = 1'b0;
    q.delete();
  endtask

  task automatic check_status(input string tag);
    int pc;
    model();
    chk({tag, ".cpu_reset"},  32'(cpu_reset),  32'(exp_st != 1));
    chk({tag, ".load_done"},  32'(load_done),  32'(exp_st == 1));
    chk({tag, ".load_err"},   32'(load_err),   32'(exp_st == 2));
    chk({tag, ".word_count"}, 32'(word_count), 32'(exp_wc));
    pc = $urandom_range(0, 63);
    PC = ADDR_W'(pc);
    #1;
    chk({tag, ".instr"}, 32'(InstructIn), 32'(exp_word(pc)));
  endtask

  task automatic check_mem(input string tag);
    model();
    for (int pc = 0; pc < 64; pc++) begin
      PC = ADDR_W'(pc);
      #1;
      chk($sformatf("%s.pc%0d", tag, pc), 32'(InstructIn), 32'(exp_word(pc)));
    end
  endtask

  // One byte per call, with optional idle cycles (random junk on rx_byte) beforehand.
  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit check);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0; rx_byte = $urandom;
      tick();
    end
    rx_valid = 1'b1; rx_byte = b;
    tick();
    rx_valid = 1'b0;
    q.push_back(b);
    if (check) check_status($sformatf("byte%0d", q.size()));
  endtask

  // Streams load_w[0..n-1] with a correct checksum, or a corrupted one when bad_chk is set.
  task automatic send_load(input int n, input bit bad_chk, input int max_gap, input bit check);
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'(n), max_gap, check);
    for (int i = 0; i < n; i++) begin
      send_byte(load_w[i][15:8], max_gap, check);
      send_byte(load_w[i][7:0],  max_gap, check);
      x ^= load_w[i][15:8] ^ load_w[i][7:0];
    end
    send_byte(bad_chk ? (x ^ 8'(1 << $urandom_range(0, 7))) : x, max_gap, check);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; PC = '0;
    tick();
    do_reset();
    check_status("reset");

    // Two-word load, good checksum 0x40.
    load_w[0] = 16'h1234; load_w[1] = 16'hABCD;
    send_load(2, 1'b0, 0, 1'b1);
    chk("t1.run_load_done", 32'(load_done), 32'd1);
    check_mem("t1");

    // Same image with checksum 0x41.
    do_reset();
    send_byte(8'h02, 0, 1'b1); send_byte(8'h12, 0, 1'b1); send_byte(8'h34, 0, 1'b1);
    send_byte(8'hAB, 0, 1'b1); send_byte(8'hCD, 0, 1'b1); send_byte(8'h41, 0, 1'b1);
    chk("t2.load_err", 32'(load_err), 32'd1);
    check_mem("t2");

    // Out-of-range headers go straight to ERR.
    do_reset();
    send_byte(8'h00, 0, 1'b1);
    chk("t3.hdr00_err", 32'(load_err), 32'd1);
    do_reset();
    check_status("t3.reset");
    send_byte(8'h41, 0, 1'b1);
    chk("t3.hdr41_err", 32'(load_err), 32'd1);
    send_byte(8'h02, 0, 1'b1);

    // Full 64-word image with random gaps.
    do_reset();
    for (int i = 0; i < 64; i++) load_w[i] = {8'(i), ~8'(i)};
    send_load(64, 1'b0, 3, 1'b1);
    chk("t4.word_count", 32'(word_count), 32'd64);
    PC = 6'd63; #1;
    chk("t4.pc63", 32'(InstructIn), 32'h3FC0);
    check_mem("t4");

    // Reset mid-load, then a fresh one-word load.
    do_reset();
    send_byte(8'h02, 0, 1'b1); send_byte(8'h11, 0, 1'b1);
    send_byte(8'h22, 0, 1'b1); send_byte(8'h33, 0, 1'b1);
    do_reset();
    check_status("t5.reset");
    send_byte(8'h01, 0, 1'b1); send_byte(8'hBE, 0, 1'b1);
    send_byte(8'hEF, 0, 1'b1); send_byte(8'h51, 0, 1'b1);
    check_mem("t5");

    // Bytes arriving in RUN are ignored.
    send_byte(8'hFF, 0, 1'b1); send_byte(8'h00, 0, 1'b1);
    chk("t6.load_done", 32'(load_done), 32'd1);
    check_mem("t6");

    // Random images, some with corrupted checksums, some truncated by reset.
    for (int r = 0; r < 6; r++) begin
      int n;
      do_reset();
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) load_w[i] = 16'($urandom);
      send_load(n, (r % 3) == 2, 2, 1'b1);
      check_mem($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
